// File: rtl/up_sample_pkg.sv
// Shared constants and helpers for the up_sample interpolation chain.
// Optional clamping of odd-phase results is enabled by defining UP_SAMPLE_SAT_EN.
package up_sample_pkg;

    localparam int unsigned C_INNER  = 9;
    localparam int unsigned C_OUTER  = 1;
    localparam int unsigned HB_SHIFT = 4;
    localparam int unsigned HB_RND   = 8;
    localparam int unsigned HB_GUARD = 5;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                               input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/up_sample_halfband_interp2.sv
// One 2x half-band interpolator stage: even phase copies a delayed sample,
// odd phase computes the 4-tap midpoint. Clamps when UP_SAMPLE_SAT_EN is defined.
module halfband_interp2
    import up_sample_pkg::*;
#(
    parameter int unsigned DW = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_lo,
    input  logic                 en_hi,
    input  logic signed [DW-1:0] data_i,
    output logic signed [DW-1:0] data_o
);

    localparam int unsigned SW = DW + HB_GUARD;
    localparam logic signed [SW-1:0] K_IN  = SW'(C_INNER);
    localparam logic signed [SW-1:0] K_OUT = SW'(C_OUTER);
    localparam logic signed [SW-1:0] K_RND = SW'(HB_RND);

    logic signed [DW-1:0] d0_q, d1_q, d2_q, d3_q, y_q;
    logic signed [DW-1:0] d0_d, d1_d, d2_d, d3_d, y_d;
    logic signed [SW-1:0] acc_c;
    logic signed [SW-1:0] shr_c;
    logic signed [DW-1:0] odd_c;

    // Odd-phase midpoint with round-half-up before the arithmetic shift.
    always_comb begin
        acc_c = K_IN * (SW'(d1_q) + SW'(d2_q)) - K_OUT * (SW'(d0_q) + SW'(d3_q)) + K_RND;
        shr_c = acc_c >>> HB_SHIFT;
`ifdef UP_SAMPLE_SAT_EN
        odd_c = DW'(sat(64'(shr_c), DW));
`else
        odd_c = DW'(shr_c);
`endif
    end

    always_comb begin
        d0_d = d0_q;
        d1_d = d1_q;
        d2_d = d2_q;
        d3_d = d3_q;
        y_d  = y_q;
        if (en_lo) begin
            d0_d = data_i;
            d1_d = d0_q;
            d2_d = d1_q;
            d3_d = d2_q;
            y_d  = d1_q;
        end else if (en_hi) begin
            y_d  = odd_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q <= '0;
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
            y_q  <= '0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
            d3_q <= d3_d;
            y_q  <= y_d;
        end
    end

    assign data_o = y_q;

endmodule

// File: rtl/up_sample.sv
// 512 Hz -> 4096 Hz interpolation chain: three cascaded 2x half-band stages
// with rate strobes divided down from en4096. UP_SAMPLE_SAT_EN enables clamping.
module up_sample
    import up_sample_pkg::*;
#(
    parameter int unsigned DW = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en4096,
    output logic                 ready,
    input  logic signed [DW-1:0] data_i,
    output logic                 valid,
    output logic signed [DW-1:0] data_o
);

    logic c1_q, c2_q, c3_q, valid_q;
    logic c1_d, c2_d, c3_d, valid_d;
    logic en2048, en1024, en512;
    logic signed [DW-1:0] s1_y, s2_y, s3_y;

    // Cascaded divide-by-2 strobes; en512 always coincides with the faster ones.
    always_comb begin
        en2048  = en4096 & c1_q;
        en1024  = en2048 & c2_q;
        en512   = en1024 & c3_q;
        c1_d    = c1_q ^ en4096;
        c2_d    = c2_q ^ en2048;
        c3_d    = c3_q ^ en1024;
        valid_d = en4096;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            c3_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            valid_q <= valid_d;
        end
    end

    // Downstream stages take the upstream y register before it updates.
    halfband_interp2 #(.DW(DW)) u_stage1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_lo  (en512),
        .en_hi  (en1024),
        .data_i (data_i),
        .data_o (s1_y)
    );

    halfband_interp2 #(.DW(DW)) u_stage2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_lo  (en1024),
        .en_hi  (en2048),
        .data_i (s1_y),
        .data_o (s2_y)
    );

    halfband_interp2 #(.DW(DW)) u_stage3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_lo  (en2048),
        .en_hi  (en4096),
        .data_i (s2_y),
        .data_o (s3_y)
    );

    assign ready  = en512;
    assign valid  = valid_q;
    assign data_o = s3_y;

endmodule

// File: tb/tb_up_sample.sv
// Self-checking bench for up_sample: scoreboard fed by a behavioural chain model,
// plus DC, ramp, impulse/latency, overshoot, idle and reset scenarios.
module tb_up_sample;

    localparam int     DW   = 24;
    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;

    logic                 clk;
    logic                 rst_n;
    logic                 en4096;
    logic                 ready;
    logic                 valid;
    logic signed [DW-1:0] data_i;
    logic signed [DW-1:0] data_o;

    up_sample #(.DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en4096 (en4096),
        .ready  (ready),
        .data_i (data_i),
        .valid  (valid),
        .data_o (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    longint md [3][4];
    longint my [3];
    bit     mc1, mc2, mc3;
    longint exp_q[$];
    int     obs[$];
    int     rdy_mark[$];
    int     rdy_cnt;
    bit     last_rdy;
    int     mode, const_val, imp_idx, step_idx;

    function automatic longint hb_odd(longint a0, longint a1, longint a2, longint a3);
        longint s;
        longint r;
        s = 9 * (a1 + a2) - (a0 + a3) + 8;
        r = s >>> 4;
`ifdef UP_SAMPLE_SAT_EN
        if (r > MAXV) r = MAXV;
        else if (r < MINV) r = MINV;
`else
        r = r & 64'hFFFFFF;
        if (r > MAXV) r = r - 64'sd16777216;
`endif
        return r;
    endfunction

    function automatic int src_val(int n);
        case (mode)
            1:       return 16 * n;
            2:       return (n == imp_idx) ? 16000 : 0;
            3:       return (n < step_idx) ? -8388608 : 8388607;
            default: return const_val;
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            my[k] = 0;
            for (int j = 0; j < 4; j++) md[k][j] = 0;
        end
        mc1 = 0; mc2 = 0; mc3 = 0;
        exp_q.delete();
        obs.delete();
        rdy_mark.delete();
        rdy_cnt = 0;
    endfunction

    function automatic void model_tick(longint x);
        bit     e2048, e1024, e512;
        bit     lo [3];
        bit     hi [3];
        longint in_v [3];
        e2048 = mc1;
        e1024 = e2048 & mc2;
        e512  = e1024 & mc3;
        lo    = '{e512, e1024, e2048};
        hi    = '{e1024, e2048, 1'b1};
        in_v  = '{x, my[0], my[1]};
        for (int k = 0; k < 3; k++) begin
            if (lo[k]) begin
                my[k]    = md[k][1];
                md[k][3] = md[k][2];
                md[k][2] = md[k][1];
                md[k][1] = md[k][0];
                md[k][0] = in_v[k];
            end else if (hi[k]) begin
                my[k] = hb_odd(md[k][0], md[k][1], md[k][2], md[k][3]);
            end
        end
        mc1 = ~mc1;
        if (e2048) mc2 = ~mc2;
        if (e1024) mc3 = ~mc3;
        exp_q.push_back(my[2]);
    endfunction

    // One clock: drive at negedge, check ready, advance model, check outputs after posedge.
    task automatic step(input bit en);
        bit     m_rdy;
        longint e;
        @(negedge clk);
        en4096 = en;
        data_i = DW'(src_val(rdy_cnt));
        m_rdy  = en && mc1 && mc2 && mc3;
        #1;
        n_checks++;
        if (ready !== m_rdy) begin
            n_fail++;
            $display("FAIL ready_strobe: got %b expected %b at t=%0t", ready, m_rdy, $time);
        end
        if (en) model_tick(longint'(src_val(rdy_cnt)));
        last_rdy = m_rdy;
        if (m_rdy) begin
            rdy_mark.push_back(obs.size());
            rdy_cnt++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (valid !== en) begin
            n_fail++;
            $display("FAIL valid_strobe: got %b expected %b at t=%0t", valid, en, $time);
        end
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: valid with no expected sample at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (data_o !== DW'(e)) begin
                    n_fail++;
                    $display("FAIL data_o: got %0d expected %0d at t=%0t", data_o, e, $time);
                end
            end
            obs.push_back(int'(data_o));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        en4096 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int find_first(int from, int val);
        for (int i = from; i < obs.size(); i++) if (obs[i] == val) return i;
        return -1;
    endfunction

    task automatic test_reset();
        int first_k;
        mode = 0; const_val = 0;
        #2 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en4096 = i[0];
            @(posedge clk);
            #1;
            n_checks++;
            if (data_o !== '0 || valid !== 1'b0 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: data_o=%0d valid=%b ready=%b expected 0/0/0", data_o, valid, ready);
            end
        end
        @(negedge clk);
        en4096 = 1'b0;
        rst_n  = 1'b1;
        first_k = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1);
            if (last_rdy && first_k == 0) first_k = k;
            step(1'b0);
        end
        n_checks++;
        if (first_k != 8) begin
            n_fail++;
            $display("FAIL first_ready: got en4096 #%0d expected #8", first_k);
        end
    endtask

    task automatic test_dc();
        int cnt;
        do_reset();
        mode = 0; const_val = 1000;
        repeat (14 * 8) begin
            step(1'b1);
            repeat (3) step(1'b0);
        end
        cnt = 0;
        for (int i = rdy_mark[9]; i < obs.size(); i++) begin
            cnt++;
            n_checks++;
            if (obs[i] != 1000) begin
                n_fail++;
                $display("FAIL dc_level: got %0d expected 1000 at output %0d", obs[i], i);
            end
        end
        n_checks++;
        if (cnt < 30) begin
            n_fail++;
            $display("FAIL dc_span: got %0d settled outputs expected at least 30", cnt);
        end
    endtask

    task automatic test_idle();
        longint hold;
        hold = my[2];
        repeat (40) step(1'b0);
        n_checks++;
        if (data_o !== DW'(hold)) begin
            n_fail++;
            $display("FAIL idle_hold: got %0d expected %0d", data_o, hold);
        end
    endtask

    task automatic run_ramp(output int lat);
        int i160;
        mode = 1;
        repeat (24 * 8) step(1'b1);
        i160 = find_first(0, 160);
        n_checks++;
        if (i160 < 0 || obs.size() < i160 + 41) begin
            n_fail++;
            $display("FAIL ramp_fill: got index %0d expected value 160 with 40 followers", i160);
            lat = -1;
        end else begin
            lat = i160 - rdy_mark[0];
            for (int j = i160; j < i160 + 40; j++) begin
                n_checks++;
                if (obs[j + 1] - obs[j] != 2) begin
                    n_fail++;
                    $display("FAIL ramp_step: got %0d -> %0d expected +2", obs[j], obs[j + 1]);
                end
            end
        end
    endtask

    task automatic test_ramp_and_mid_reset();
        int lat1, lat2;
        do_reset();
        run_ramp(lat1);
        do_reset();
        mode = 1;
        repeat (10 * 8) step(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_o !== '0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: data_o=%0d valid=%b expected 0/0", data_o, valid);
        end
        en4096 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_ramp(lat2);
        n_checks++;
        if (lat2 != lat1 || lat1 < 0) begin
            n_fail++;
            $display("FAIL ramp_latency: got %0d expected %0d", lat2, lat1);
        end
    endtask

    task automatic test_impulse();
        int lat [2];
        int p, pk;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            mode = 2; imp_idx = 4;
            repeat (14 * 8) begin
                step(1'b1);
                step(1'b0);
            end
            p = 0; pk = obs[0];
            for (int i = 1; i < obs.size(); i++) if (obs[i] > pk) begin pk = obs[i]; p = i; end
            n_checks++;
            if (pk != 16000) begin
                n_fail++;
                $display("FAIL impulse_peak: got %0d expected 16000", pk);
            end
            lat[r] = p - rdy_mark[imp_idx];
            for (int i = 1; i <= 24; i++) begin
                if (p - i >= 0 && p + i < obs.size()) begin
                    n_checks++;
                    if (obs[p - i] != obs[p + i]) begin
                        n_fail++;
                        $display("FAIL impulse_symmetry: got %0d vs %0d at offset %0d", obs[p - i], obs[p + i], i);
                    end
                end
            end
        end
        n_checks++;
        if (lat[0] != lat[1]) begin
            n_fail++;
            $display("FAIL impulse_latency: got %0d expected %0d", lat[1], lat[0]);
        end
    endtask

    task automatic test_overshoot();
        int f, nneg;
        do_reset();
        mode = 3; step_idx = 6;
        repeat (16 * 8) begin
            step(1'b1);
            step(1'b0);
        end
        f = find_first(rdy_mark[step_idx], 8388607);
        n_checks++;
        if (f < 0) begin
            n_fail++;
            $display("FAIL overshoot_peak: got no 8388607 output expected one");
        end else begin
            nneg = 0;
            for (int i = f; i < obs.size(); i++) if (obs[i] < 0) nneg++;
            n_checks++;
`ifdef UP_SAMPLE_SAT_EN
            if (nneg != 0) begin
                n_fail++;
                $display("FAIL overshoot_clamp: got %0d negative outputs expected 0", nneg);
            end
`else
            if (nneg == 0) begin
                n_fail++;
                $display("FAIL overshoot_wrap: got 0 negative outputs expected a wrapped one");
            end
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        en4096   = 1'b0;
        data_i   = '0;
        mode = 0; const_val = 0; imp_idx = 0; step_idx = 0;
        model_reset();
        test_reset();
        test_dc();
        test_idle();
        test_ramp_and_mid_reset();
        test_impulse();
        test_overshoot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
